// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file writeback arbiter.
// Register addressing is fixed by the RV32 integer register file.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [NUM_REGS-1:0]   reg_mask_t;

    function automatic reg_mask_t reg_onehot(input reg_addr_t a);
        reg_mask_t m;
        m    = '0;
        m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin grant over NREQ requesters; the pointer advances past
// the winner so every requester waits at most NREQ-1 cycles.
module rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = (NREQ > 2) ? 2 : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic             gnt_any,
    output logic [PTR_W-1:0] gnt_idx
);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] ptr_nxt;

    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(rr_ptr) + k) % NREQ;
            if (!gnt_any && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_any = 1'b1;
                gnt_idx = PTR_W'(j);
            end
        end
    end

    always_comb begin
        if (int'(gnt_idx) + 1 >= NREQ) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among writeback sources and keeps
// a pending-write scoreboard for RAW stalls in the issue stage.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int NREQ   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          wb_valid_i,
    input  logic [NREQ*5-1:0]        wb_rd_i,
    input  logic [NREQ*DWIDTH-1:0]   wb_data_i,
    output logic [NREQ-1:0]          wb_ready_o,
    input  logic                     alloc_valid_i,
    input  logic [4:0]               alloc_rd_i,
    output logic                     alloc_ready_o,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    output logic                     rs1_busy_o,
    output logic                     rs2_busy_o,
    output logic [4:0]               rd_o,
    output logic [DWIDTH-1:0]        datawb_o,
    output logic                     regwren_o,
    output logic                     wb_orphan_o
);

    localparam int PTR_W = (NREQ > 2) ? 2 : 1;

    typedef struct packed {
        reg_addr_t         rd;
        logic [DWIDTH-1:0] data;
    } wb_req_t;

    wb_req_t          reqs [NREQ];
    wb_req_t          sel;
    logic [NREQ-1:0]  req_gated;
    logic [NREQ-1:0]  gnt;
    logic             gnt_any;
    logic [PTR_W-1:0] gnt_idx;

    reg_mask_t        pending;
    reg_mask_t        pending_nxt;
    logic             alloc_fire;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            reqs[i].rd   = wb_rd_i[i*REG_ADDR_W +: REG_ADDR_W];
            reqs[i].data = wb_data_i[i*DWIDTH +: DWIDTH];
        end
    end

    // Reset masks requests so no handshake can complete while held.
    assign req_gated = wb_valid_i & {NREQ{rst}};

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_gated),
        .gnt     (gnt),
        .gnt_any (gnt_any),
        .gnt_idx (gnt_idx)
    );

    assign wb_ready_o = gnt;
    assign sel        = reqs[gnt_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            regwren_o <= 1'b0;
            rd_o      <= '0;
            datawb_o  <= '0;
        end else if (gnt_any) begin
            regwren_o <= (sel.rd != '0);
            rd_o      <= sel.rd;
            datawb_o  <= sel.data;
        end else begin
            regwren_o <= 1'b0;
        end
    end

    // Uses the pre-commit bit, so a same-cycle re-alloc is refused.
    assign alloc_ready_o = rst & ((alloc_rd_i == '0) | ~pending[alloc_rd_i]);
    assign alloc_fire    = alloc_valid_i & alloc_ready_o & (alloc_rd_i != '0);

    always_comb begin
        pending_nxt = pending;
        if (regwren_o) begin
            pending_nxt = pending_nxt & ~reg_onehot(rd_o);
        end
        if (alloc_fire) begin
            pending_nxt = pending_nxt | reg_onehot(alloc_rd_i);
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign wb_orphan_o = rst & regwren_o & ~pending[rd_o];

    // The committing register is forwarded by register_file this cycle.
    assign rs1_busy_o = (rs1_i != '0) & pending[rs1_i]
                      & ~(regwren_o & (rd_o == rs1_i));
    assign rs2_busy_o = (rs2_i != '0) & pending[rs2_i]
                      & ~(regwren_o & (rd_o == rs2_i));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, latency,
// x0 handling, orphan pulses, scoreboard hazards and mid-flight reset.
module tb_regfile_wb_arbiter;

    localparam int DWIDTH = 32;
    localparam int NREQ   = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        wb_valid_i;
    logic [NREQ*5-1:0]      wb_rd_i;
    logic [NREQ*DWIDTH-1:0] wb_data_i;
    logic [NREQ-1:0]        wb_ready_o;
    logic                   alloc_valid_i;
    logic [4:0]             alloc_rd_i;
    logic                   alloc_ready_o;
    logic [4:0]             rs1_i;
    logic [4:0]             rs2_i;
    logic                   rs1_busy_o;
    logic                   rs2_busy_o;
    logic [4:0]             rd_o;
    logic [DWIDTH-1:0]      datawb_o;
    logic                   regwren_o;
    logic                   wb_orphan_o;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(
        .DWIDTH (DWIDTH),
        .NREQ   (NREQ)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_valid_i    (wb_valid_i),
        .wb_rd_i       (wb_rd_i),
        .wb_data_i     (wb_data_i),
        .wb_ready_o    (wb_ready_o),
        .alloc_valid_i (alloc_valid_i),
        .alloc_rd_i    (alloc_rd_i),
        .alloc_ready_o (alloc_ready_o),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .rs1_busy_o    (rs1_busy_o),
        .rs2_busy_o    (rs2_busy_o),
        .rd_o          (rd_o),
        .datawb_o      (datawb_o),
        .regwren_o     (regwren_o),
        .wb_orphan_o   (wb_orphan_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_single(input int idx, input logic [4:0] rd,
                             input logic [31:0] data,
                             input logic exp_wren, input logic exp_orph);
        wb_valid_i                 = '0;
        wb_valid_i[idx]            = 1'b1;
        wb_rd_i[idx*5 +: 5]        = rd;
        wb_data_i[idx*DWIDTH +: DWIDTH] = data;
        #1;
        chk("single_ready", 32'(wb_ready_o), 32'(1) << idx);
        tick();
        wb_valid_i = '0;
        #1;
        chk("single_wren", 32'(regwren_o), 32'(exp_wren));
        chk("single_rd", 32'(rd_o), 32'(rd));
        chk("single_data", datawb_o, data);
        chk("single_orph", 32'(wb_orphan_o), 32'(exp_orph));
        tick();
        chk("single_wren_off", 32'(regwren_o), 32'd0);
        chk("single_orph_off", 32'(wb_orphan_o), 32'd0);
    endtask

    task automatic contend(input int first);
        int second;
        second     = 1 - first;
        wb_rd_i    = {5'd4, 5'd3};
        wb_data_i  = {32'h22, 32'h11};
        wb_valid_i = 2'b11;
        #1;
        chk("ct_gnt_a", 32'(wb_ready_o), 32'(1) << first);
        tick();
        wb_valid_i[first] = 1'b0;
        #1;
        chk("ct_gnt_b", 32'(wb_ready_o), 32'(1) << second);
        chk("ct_wren_a", 32'(regwren_o), 32'd1);
        chk("ct_rd_a", 32'(rd_o), (first == 0) ? 32'd3 : 32'd4);
        chk("ct_data_a", datawb_o, (first == 0) ? 32'h11 : 32'h22);
        chk("ct_orph_a", 32'(wb_orphan_o), 32'd1);
        tick();
        wb_valid_i = '0;
        #1;
        chk("ct_wren_b", 32'(regwren_o), 32'd1);
        chk("ct_rd_b", 32'(rd_o), (first == 0) ? 32'd4 : 32'd3);
        chk("ct_data_b", datawb_o, (first == 0) ? 32'h22 : 32'h11);
        tick();
        chk("ct_wren_off", 32'(regwren_o), 32'd0);
    endtask

    initial begin
        rst           = 1'b0;
        wb_valid_i    = '0;
        wb_rd_i       = '0;
        wb_data_i     = '0;
        alloc_valid_i = 1'b0;
        alloc_rd_i    = '0;
        rs1_i         = '0;
        rs2_i         = '0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wren", 32'(regwren_o), 32'd0);
        chk("rst_rd", 32'(rd_o), 32'd0);
        chk("rst_data", datawb_o, 32'd0);
        chk("rst_orph", 32'(wb_orphan_o), 32'd0);
        wb_valid_i    = 2'b11;
        alloc_valid_i = 1'b1;
        alloc_rd_i    = 5'd5;
        #1;
        chk("rst_ready", 32'(wb_ready_o), 32'd0);
        chk("rst_alloc_rdy", 32'(alloc_ready_o), 32'd0);
        tick();
        chk("rst_wren_held", 32'(regwren_o), 32'd0);
        wb_valid_i    = '0;
        alloc_valid_i = 1'b0;
        for (int r = 0; r < 32; r++) begin
            rs1_i = 5'(r);
            #1;
            chk("idle_busy", 32'(rs1_busy_o), 32'd0);
        end
        rst = 1'b1;
        tick();

        // Single requester with reservation
        alloc_valid_i = 1'b1;
        alloc_rd_i    = 5'd5;
        #1;
        chk("t2_alloc_rdy", 32'(alloc_ready_o), 32'd1);
        tick();
        alloc_valid_i = 1'b0;
        rs1_i         = 5'd5;
        #1;
        chk("t2_busy_pre", 32'(rs1_busy_o), 32'd1);
        wb_rd_i    = {5'd0, 5'd5};
        wb_data_i  = {32'h0, 32'hDEADBEEF};
        wb_valid_i = 2'b01;
        #1;
        chk("t2_ready", 32'(wb_ready_o), 32'd1);
        tick();
        wb_valid_i = '0;
        #1;
        chk("t2_wren", 32'(regwren_o), 32'd1);
        chk("t2_rd", 32'(rd_o), 32'd5);
        chk("t2_data", datawb_o, 32'hDEADBEEF);
        chk("t2_busy_fwd", 32'(rs1_busy_o), 32'd0);
        chk("t2_orph", 32'(wb_orphan_o), 32'd0);
        tick();
        chk("t2_wren_off", 32'(regwren_o), 32'd0);
        chk("t2_busy_post", 32'(rs1_busy_o), 32'd0);
        chk("t2_cleared", 32'(alloc_ready_o), 32'd1);

        // Unreserved write from req1 (pointer now at 1) pulses orphan
        wb_single(1, 5'd7, 32'h77, 1'b1, 1'b1);

        // Contention with pointer at 0, then x0 write, then pointer at 1
        contend(0);
        wb_single(0, 5'd0, 32'h55, 1'b0, 1'b0);
        contend(1);

        // x0 alloc is accepted and never recorded
        alloc_valid_i = 1'b1;
        alloc_rd_i    = 5'd0;
        rs1_i         = 5'd0;
        #1;
        chk("x0_alloc_rdy", 32'(alloc_ready_o), 32'd1);
        tick();
        alloc_valid_i = 1'b0;
        chk("x0_busy", 32'(rs1_busy_o), 32'd0);

        // Scoreboard hazard on x9
        alloc_valid_i = 1'b1;
        alloc_rd_i    = 5'd9;
        tick();
        rs2_i = 5'd9;
        #1;
        chk("t5_realloc_rdy", 32'(alloc_ready_o), 32'd0);
        chk("t5_busy", 32'(rs2_busy_o), 32'd1);
        alloc_valid_i = 1'b0;
        wb_rd_i    = {5'd0, 5'd9};
        wb_data_i  = {32'h0, 32'h99};
        wb_valid_i = 2'b01;
        #1;
        chk("t5_ready", 32'(wb_ready_o), 32'd1);
        tick();
        wb_valid_i    = '0;
        alloc_valid_i = 1'b1;
        #1;
        chk("t5_commit_wren", 32'(regwren_o), 32'd1);
        chk("t5_commit_rdy", 32'(alloc_ready_o), 32'd0);
        chk("t5_commit_busy", 32'(rs2_busy_o), 32'd0);
        chk("t5_commit_orph", 32'(wb_orphan_o), 32'd0);
        tick();
        chk("t5_retry_rdy", 32'(alloc_ready_o), 32'd1);
        tick();
        alloc_valid_i = 1'b0;
        #1;
        chk("t5_busy_new", 32'(rs2_busy_o), 32'd1);
        chk("t5_alloc_blk", 32'(alloc_ready_o), 32'd0);

        // Reset while a granted write is in flight
        alloc_valid_i = 1'b1;
        alloc_rd_i    = 5'd12;
        tick();
        alloc_valid_i = 1'b0;
        wb_rd_i    = {5'd0, 5'd12};
        wb_data_i  = {32'h0, 32'hC0C0};
        wb_valid_i = 2'b01;
        #1;
        chk("t6_ready", 32'(wb_ready_o), 32'd1);
        tick();
        wb_valid_i = '0;
        rst        = 1'b0;
        #1;
        chk("t6_orph_inrst", 32'(wb_orphan_o), 32'd0);
        tick();
        chk("t6_wren", 32'(regwren_o), 32'd0);
        chk("t6_orph", 32'(wb_orphan_o), 32'd0);
        chk("t6_rd", 32'(rd_o), 32'd0);
        rst   = 1'b1;
        rs1_i = 5'd9;
        rs2_i = 5'd12;
        alloc_rd_i = 5'd9;
        #1;
        chk("t6_busy9", 32'(rs1_busy_o), 32'd0);
        chk("t6_busy12", 32'(rs2_busy_o), 32'd0);
        chk("t6_alloc_rdy", 32'(alloc_ready_o), 32'd1);
        tick();
        chk("t6_orph_after", 32'(wb_orphan_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
